// File: rtl/gem_link_pkg.sv
// Shared definitions for the GEM trigger link framer.
//
// Holds the 8b/10b K-character frame markers, the idle word, the number of
// transmit words per bunch crossing, and small helpers used by the framer
// core (marker selection) and by the top level (bitwise 2-of-3 vote).
package gem_link_pkg;

  localparam logic [7:0]  K_IDLE      = 8'hBC;  // K28.5
  localparam logic [7:0]  K_BC0       = 8'h1C;  // K28.0
  localparam logic [7:0]  K_RESYNC    = 8'h3C;  // K28.1
  localparam logic [7:0]  K_OVF       = 8'hFC;  // K28.7
  localparam logic [15:0] IDLE_WORD   = 16'h00BC;
  localparam int          FRAME_WORDS = 4;

  typedef logic [$clog2(FRAME_WORDS)-1:0] frame_t;

  // Per-BX control flags, in marker priority order (MSB wins).
  typedef struct packed {
    logic resync;
    logic bc0;
    logic overflow;
  } bx_flags_t;

  // One transmit word with its charisk bits (bit n flags byte n).
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  isk;
  } tx_word_t;

  localparam tx_word_t IDLE_TX = '{data: IDLE_WORD, isk: 2'b01};

  // Frame marker for the first word of a BX. TTC flags are only honoured
  // when the link is allowed to carry them; overflow is always reported.
  function automatic logic [7:0] frame_marker(input bx_flags_t flags,
                                              input logic      allow_ttc);
    if (allow_ttc && flags.resync)  return K_RESYNC;
    else if (allow_ttc && flags.bc0) return K_BC0;
    else if (flags.overflow)         return K_OVF;
    else                             return K_IDLE;
  endfunction

  // Bitwise majority of three copies of a transmit word.
  function automatic tx_word_t vote3(input tx_word_t a,
                                     input tx_word_t b,
                                     input tx_word_t c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/gem_trig_link_framer_core.sv
// Single (non-redundant) copy of the GEM trigger link framer.
//
// Splits one BX of cluster data into four 16-bit words per link; the first
// word carries a K-character frame marker in its low byte. Frame phase is
// optionally realigned to the 40 MHz BX counter LSBs.
//
// Ports:
//   clk_160          160 MHz transmit user clock
//   reset_n          synchronous active-low reset
//   gem_data         [55:0] link A slice, [111:56] link B slice
//   overflow_i       more than 8 clusters in this BX
//   bxn_counter_lsbs BX counter bits [1:0]
//   bc0_i, resync_i  TTC flags for this BX
//   ready            transceiver ready; 0 forces idle output
//   tx_a, tx_b       registered transmit word + charisk for links A and B
module gem_trig_link_framer_core
  import gem_link_pkg::*;
#(
  parameter int ALLOW_TTC_CHARS = 1,
  parameter int FRAME_CTRL_TTC  = 1
) (
  input  logic         clk_160,
  input  logic         reset_n,
  input  logic [111:0] gem_data,
  input  logic         overflow_i,
  input  logic [1:0]   bxn_counter_lsbs,
  input  logic         bc0_i,
  input  logic         resync_i,
  input  logic         ready,
  output tx_word_t     tx_a,
  output tx_word_t     tx_b
);

  frame_t       fc;
  frame_t       fe;
  logic [1:0]   lsbs_q;
  logic         bx_strobe;
  logic [111:0] hold_data;
  bx_flags_t    hold_flags;
  logic         active;
  logic         emit;

  logic [111:0] d;
  bx_flags_t    flags;
  logic [7:0]   k_char;
  tx_word_t     word_a;
  tx_word_t     word_b;

  // Output registers kept as separate variables so each copy can be
  // observed or disturbed individually.
  logic [15:0]  data_a_q;
  logic [1:0]   isk_a_q;
  logic [15:0]  data_b_q;
  logic [1:0]   isk_b_q;

  // A change of the BX counter LSBs marks the start of a new BX.
  assign bx_strobe = (bxn_counter_lsbs != lsbs_q);
  assign fe        = ((FRAME_CTRL_TTC != 0) && bx_strobe) ? '0 : fc;

  // Frame 0 uses the live inputs; later frames use what was captured then.
  assign d      = (fe == '0) ? gem_data : hold_data;
  assign flags  = (fe == '0) ? bx_flags_t'{resync: resync_i, bc0: bc0_i, overflow: overflow_i}
                             : hold_flags;
  assign k_char = frame_marker(flags, ALLOW_TTC_CHARS != 0);

  // After ready rises, stay idle until the next frame-0 word so the link
  // never starts in the middle of a BX.
  assign emit = ready && (active || fe == '0);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    word_a = IDLE_TX;
    word_b = IDLE_TX;
    case (fe)
      2'd0: begin
        word_a = '{data: {d[7:0],  k_char}, isk: 2'b01};
        word_b = '{data: {d[63:56], k_char}, isk: 2'b01};
      end
      2'd1: begin
        word_a = '{data: d[23:8],   isk: 2'b00};
        word_b = '{data: d[79:64],  isk: 2'b00};
      end
      2'd2: begin
        word_a = '{data: d[39:24],  isk: 2'b00};
        word_b = '{data: d[95:80],  isk: 2'b00};
      end
      2'd3: begin
        word_a = '{data: d[55:40],  isk: 2'b00};
        word_b = '{data: d[111:96], isk: 2'b00};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_160) begin
    if (!reset_n) begin
      fc         <= '0;
      lsbs_q     <= '0;
      // NOTE: the BX hold registers are reset too, so a BX aborted by reset
      // cannot leak stale payload into the words after release.
      hold_data  <= '0;
      hold_flags <= '0;
      active     <= 1'b0;
      data_a_q   <= IDLE_WORD;
      isk_a_q    <= 2'b01;
      data_b_q   <= IDLE_WORD;
      isk_b_q    <= 2'b01;
    end else begin
      lsbs_q <= bxn_counter_lsbs;
      fc     <= fe + frame_t'(1);
      active <= emit;
      if (fe == '0) begin
        hold_data  <= gem_data;
        hold_flags <= '{resync: resync_i, bc0: bc0_i, overflow: overflow_i};
      end
      if (emit) begin
        data_a_q <= word_a.data;
        isk_a_q  <= word_a.isk;
        data_b_q <= word_b.data;
        isk_b_q  <= word_b.isk;
      end else begin
        data_a_q <= IDLE_WORD;
        isk_a_q  <= 2'b01;
        data_b_q <= IDLE_WORD;
        isk_b_q  <= 2'b01;
      end
    end
  end

  assign tx_a = '{data: data_a_q, isk: isk_a_q};
  assign tx_b = '{data: data_b_q, isk: isk_b_q};

endmodule

// File: rtl/gem_trig_link_framer.sv
// GEM trigger link framer, top level.
//
// Instantiates one framer core, or three cores with a bitwise 2-of-3 vote on
// every output bit so a single upset register in one copy is masked.
//
// Ports:
//   clk_160          160 MHz transmit user clock
//   reset_n          synchronous active-low reset
//   gem_data         [55:0] link A, [111:56] link B, held for one BX
//   overflow_i       more than 8 clusters in this BX
//   bxn_counter_lsbs BX counter bits [1:0]
//   bc0_i, resync_i  TTC flags for this BX
//   ready            transceiver ready; 0 forces idle output
//   trg_tx_data_a/b  transmit words for links A and B
//   trg_tx_isk_a/b   charisk for links A and B
module gem_trig_link_framer
  import gem_link_pkg::*;
#(
  parameter int ALLOW_TTC_CHARS = 1,
  parameter int FRAME_CTRL_TTC  = 1,
  parameter int ENABLE_TMR      = 1
) (
  input  logic         clk_160,
  input  logic         reset_n,
  input  logic [111:0] gem_data,
  input  logic         overflow_i,
  input  logic [1:0]   bxn_counter_lsbs,
  input  logic         bc0_i,
  input  logic         resync_i,
  input  logic         ready,
  output logic [15:0]  trg_tx_data_a,
  output logic [1:0]   trg_tx_isk_a,
  output logic [15:0]  trg_tx_data_b,
  output logic [1:0]   trg_tx_isk_b
);

  tx_word_t tx_a;
  tx_word_t tx_b;

  if (ENABLE_TMR != 0) begin : g_tmr
    tx_word_t a0, a1, a2;
    tx_word_t b0, b1, b2;

    gem_trig_link_framer_core #(
      .ALLOW_TTC_CHARS(ALLOW_TTC_CHARS), .FRAME_CTRL_TTC(FRAME_CTRL_TTC)
    ) u_core0 (
      .clk_160(clk_160), .reset_n(reset_n), .gem_data(gem_data),
      .overflow_i(overflow_i), .bxn_counter_lsbs(bxn_counter_lsbs),
      .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
      .tx_a(a0), .tx_b(b0)
    );

    gem_trig_link_framer_core #(
      .ALLOW_TTC_CHARS(ALLOW_TTC_CHARS), .FRAME_CTRL_TTC(FRAME_CTRL_TTC)
    ) u_core1 (
      .clk_160(clk_160), .reset_n(reset_n), .gem_data(gem_data),
      .overflow_i(overflow_i), .bxn_counter_lsbs(bxn_counter_lsbs),
      .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
      .tx_a(a1), .tx_b(b1)
    );

    gem_trig_link_framer_core #(
      .ALLOW_TTC_CHARS(ALLOW_TTC_CHARS), .FRAME_CTRL_TTC(FRAME_CTRL_TTC)
    ) u_core2 (
      .clk_160(clk_160), .reset_n(reset_n), .gem_data(gem_data),
      .overflow_i(overflow_i), .bxn_counter_lsbs(bxn_counter_lsbs),
      .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
      .tx_a(a2), .tx_b(b2)
    );

    assign tx_a = vote3(a0, a1, a2);
    assign tx_b = vote3(b0, b1, b2);
  end else begin : g_single
    gem_trig_link_framer_core #(
      .ALLOW_TTC_CHARS(ALLOW_TTC_CHARS), .FRAME_CTRL_TTC(FRAME_CTRL_TTC)
    ) u_core (
      .clk_160(clk_160), .reset_n(reset_n), .gem_data(gem_data),
      .overflow_i(overflow_i), .bxn_counter_lsbs(bxn_counter_lsbs),
      .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
      .tx_a(tx_a), .tx_b(tx_b)
    );
  end

  assign trg_tx_data_a = tx_a.data;
  assign trg_tx_isk_a  = tx_a.isk;
  assign trg_tx_data_b = tx_b.data;
  assign trg_tx_isk_b  = tx_b.isk;

endmodule

// File: tb/tb_gem_trig_link_framer.sv
// Self-checking bench for gem_trig_link_framer. A default-parameter DUT
// (TTC markers on, realignment on, TMR on) and a second DUT with TTC markers
// disabled and a single core share all inputs.
module tb_gem_trig_link_framer;

  logic         clk_160 = 1'b0;
  logic         reset_n;
  logic [111:0] gem_data;
  logic         overflow_i;
  logic [1:0]   bxn_counter_lsbs;
  logic         bc0_i;
  logic         resync_i;
  logic         ready;

  logic [15:0]  data_a, data_b, nt_data_a, nt_data_b;
  logic [1:0]   isk_a, isk_b, nt_isk_a, nt_isk_b;

  always #5 clk_160 = ~clk_160;

  gem_trig_link_framer dut (
    .clk_160(clk_160), .reset_n(reset_n), .gem_data(gem_data),
    .overflow_i(overflow_i), .bxn_counter_lsbs(bxn_counter_lsbs),
    .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
    .trg_tx_data_a(data_a), .trg_tx_isk_a(isk_a),
    .trg_tx_data_b(data_b), .trg_tx_isk_b(isk_b)
  );

  gem_trig_link_framer #(.ALLOW_TTC_CHARS(0), .ENABLE_TMR(0)) dut_nt (
    .clk_160(clk_160), .reset_n(reset_n), .gem_data(gem_data),
    .overflow_i(overflow_i), .bxn_counter_lsbs(bxn_counter_lsbs),
    .bc0_i(bc0_i), .resync_i(resync_i), .ready(ready),
    .trg_tx_data_a(nt_data_a), .trg_tx_isk_a(nt_isk_a),
    .trg_tx_data_b(nt_data_b), .trg_tx_isk_b(nt_isk_b)
  );

  typedef struct {
    logic [55:0]           a;
    logic [55:0]           b;
    logic                  resync;
    logic                  bc0;
    logic                  ovf;
    logic [0:3][15:0]      exp_a;
    logic [0:3][15:0]      exp_b;
    logic [15:0]           exp_nt0;  // link A frame-0 word with TTC markers off
  } vec_t;

  localparam logic [55:0] A0 = 56'h00112233445566;
  localparam logic [55:0] B0 = 56'h8899AABBCCDDEE;
  localparam logic [55:0] A1 = 56'h0123456789ABCD;
  localparam logic [55:0] B1 = 56'hFEDCBA98765432;
  localparam logic [17:0] IDLE = {2'b01, 16'h00BC};

  vec_t vecs[6];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got isk=%b data=%h, expected isk=%b data=%h",
               name, act[17:16], act[15:0], exp[17:16], exp[15:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk_160);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " A"},    {isk_a, data_a},       IDLE);
    check({tag, " B"},    {isk_b, data_b},       IDLE);
    check({tag, " ntA"},  {nt_isk_a, nt_data_a}, IDLE);
  endtask

  // Word w of a BX: frame 0 carries the marker and isk 01, the rest isk 00.
  task automatic check_word(input string tag, input int w,
                            input logic [15:0] ea, input logic [15:0] eb,
                            input logic [15:0] ent);
    logic [1:0] ei;
    ei = (w == 0) ? 2'b01 : 2'b00;
    check($sformatf("%s w%0d A", tag, w),   {isk_a, data_a},       {ei, ea});
    check($sformatf("%s w%0d B", tag, w),   {isk_b, data_b},       {ei, eb});
    check($sformatf("%s w%0d ntA", tag, w), {nt_isk_a, nt_data_a}, {ei, ent});
  endtask

  task automatic drive_bx(input logic [55:0] a, input logic [55:0] b,
                          input logic r, input logic bc, input logic ov);
    gem_data   = {b, a};
    resync_i   = r;
    bc0_i      = bc;
    overflow_i = ov;
  endtask

  // Inputs other than the BX counter only matter in frame 0; junk them
  // afterwards so the later words must come from the captured copy.
  task automatic scramble();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    gem_data   = r[111:0];
    resync_i   = 1'($urandom_range(1));
    bc0_i      = 1'($urandom_range(1));
    overflow_i = 1'($urandom_range(1));
  endtask

  task automatic next_bx();
    bxn_counter_lsbs = bxn_counter_lsbs + 2'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{a: A0, b: B0, resync: 1'b0, bc0: 1'b0, ovf: 1'b0,
                exp_a: {16'h66BC, 16'h4455, 16'h2233, 16'h0011},
                exp_b: {16'hEEBC, 16'hCCDD, 16'hAABB, 16'h8899}, exp_nt0: 16'h66BC};
    vecs[1] = '{a: A1, b: B1, resync: 1'b0, bc0: 1'b1, ovf: 1'b0,
                exp_a: {16'hCD1C, 16'h89AB, 16'h4567, 16'h0123},
                exp_b: {16'h321C, 16'h7654, 16'hBA98, 16'hFEDC}, exp_nt0: 16'hCDBC};
    vecs[2] = '{a: A0, b: B0, resync: 1'b1, bc0: 1'b1, ovf: 1'b0,
                exp_a: {16'h663C, 16'h4455, 16'h2233, 16'h0011},
                exp_b: {16'hEE3C, 16'hCCDD, 16'hAABB, 16'h8899}, exp_nt0: 16'h66BC};
    vecs[3] = '{a: A1, b: B1, resync: 1'b0, bc0: 1'b0, ovf: 1'b1,
                exp_a: {16'hCDFC, 16'h89AB, 16'h4567, 16'h0123},
                exp_b: {16'h32FC, 16'h7654, 16'hBA98, 16'hFEDC}, exp_nt0: 16'hCDFC};
    vecs[4] = '{a: A0, b: B0, resync: 1'b1, bc0: 1'b1, ovf: 1'b1,
                exp_a: {16'h663C, 16'h4455, 16'h2233, 16'h0011},
                exp_b: {16'hEE3C, 16'hCCDD, 16'hAABB, 16'h8899}, exp_nt0: 16'h66FC};
    vecs[5] = '{a: A1, b: B1, resync: 1'b0, bc0: 1'b1, ovf: 1'b1,
                exp_a: {16'hCD1C, 16'h89AB, 16'h4567, 16'h0123},
                exp_b: {16'h321C, 16'h7654, 16'hBA98, 16'hFEDC}, exp_nt0: 16'hCDFC};

    reset_n          = 1'b0;
    ready            = 1'b0;
    bxn_counter_lsbs = 2'd0;
    drive_bx(A0, B0, 1'b0, 1'b0, 1'b0);

    // Reset held for four cycles: idle every cycle.
    for (int i = 0; i < 4; i++) begin
      tick();
      check_idle($sformatf("reset c%0d", i));
    end

    // Out of reset but not ready: idle while the BX counter keeps moving.
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) next_bx();
      tick();
      check_idle($sformatf("notready c%0d", i));
    end

    // ready rises in frame 2: frames 2 and 3 of this BX must stay idle.
    next_bx();
    tick(); check_idle("rdy f0");
    tick(); check_idle("rdy f1");
    ready = 1'b1;
    tick(); check_idle("rdy f2");
    tick(); check_idle("rdy f3");

    // Table of BXs: plain data and each marker priority case.
    for (int v = 0; v < 6; v++) begin
      next_bx();
      drive_bx(vecs[v].a, vecs[v].b, vecs[v].resync, vecs[v].bc0, vecs[v].ovf);
      for (int w = 0; w < 4; w++) begin
        if (w > 0) scramble();
        tick();
        check_word($sformatf("vec%0d", v), w, vecs[v].exp_a[w], vecs[v].exp_b[w],
                   (w == 0) ? vecs[v].exp_nt0 : vecs[v].exp_a[w]);
      end
    end

    // Realignment: BX counter moves two clocks early; the new frame 0
    // follows it immediately and its data words are intact.
    next_bx();
    drive_bx(A0, B0, 1'b0, 1'b0, 1'b0);
    tick(); check_word("align old", 0, 16'h66BC, 16'hEEBC, 16'h66BC);
    scramble();
    tick(); check_word("align old", 1, 16'h4455, 16'hCCDD, 16'h4455);
    next_bx();
    drive_bx(A1, B1, 1'b0, 1'b0, 1'b0);
    tick(); check_word("align new", 0, 16'hCDBC, 16'h32BC, 16'hCDBC);
    scramble();
    tick(); check_word("align new", 1, 16'h89AB, 16'h7654, 16'h89AB);
    tick(); check_word("align new", 2, 16'h4567, 16'hBA98, 16'h4567);
    tick(); check_word("align new", 3, 16'h0123, 16'hFEDC, 16'h0123);

    // Reset during frame 2 aborts the BX; framing restarts at frame 0.
    next_bx();
    drive_bx(A0, B0, 1'b0, 1'b0, 1'b0);
    tick(); check_word("mrst", 0, 16'h66BC, 16'hEEBC, 16'h66BC);
    scramble();
    tick(); check_word("mrst", 1, 16'h4455, 16'hCCDD, 16'h4455);
    reset_n = 1'b0;
    tick(); check_idle("mrst f2");
    reset_n = 1'b1;
    drive_bx(A1, B1, 1'b0, 1'b0, 1'b0);
    tick(); check_word("mrst rel", 0, 16'hCDBC, 16'h32BC, 16'hCDBC);
    scramble();
    tick(); check_word("mrst rel", 1, 16'h89AB, 16'h7654, 16'h89AB);
    tick(); check_word("mrst rel", 2, 16'h4567, 16'hBA98, 16'h4567);
    tick(); check_word("mrst rel", 3, 16'h0123, 16'hFEDC, 16'h0123);

    // One core's link-A output register stuck high: the vote masks it.
    next_bx();
    drive_bx(A0, B0, 1'b0, 1'b1, 1'b0);
    force dut.g_tmr.u_core1.data_a_q = 16'hFFFF;
    force dut.g_tmr.u_core1.isk_a_q  = 2'b11;
    tick(); check_word("tmr", 0, 16'h661C, 16'hEE1C, 16'h66BC);
    scramble();
    tick(); check_word("tmr", 1, 16'h4455, 16'hCCDD, 16'h4455);
    tick(); check_word("tmr", 2, 16'h2233, 16'hAABB, 16'h2233);
    tick(); check_word("tmr", 3, 16'h0011, 16'h8899, 16'h0011);
    release dut.g_tmr.u_core1.data_a_q;
    release dut.g_tmr.u_core1.isk_a_q;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
